game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_ctrl_ps2_key_decoder.sv | 29 ++
 rtl/game_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared scan codes, FSM state encoding and score width for the game controller.
// GAME_CTRL_PAUSE_EN adds the PAUSE state encoding.
package game_pkg;

    localparam int SCORE_W = 4;

    localparam logic [7:0] KEY_P0_UP = 8'h1D;
    localparam logic [7:0] KEY_P0_DN = 8'h1B;
    localparam logic [7:0] KEY_P1_UP = 8'h43;
    localparam logic [7:0] KEY_P1_DN = 8'h42;
    localparam logic [7:0] KEY_START = 8'h29;
    localparam logic [7:0] KEY_PAUSE = 8'h4D;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
`ifdef GAME_CTRL_PAUSE_EN
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
`else
        ST_OVER  = 3'd4
`endif
    } state_t;

    // Scores stick at full scale instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_ctrl_ps2_key_decoder.sv
// PS/2 make/break decoder: an F0 prefix turns the following byte into a release.
module ps2_key_decoder
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    output logic [7:0] code,
    output logic       make,
    output logic       brk
);

    logic brk_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brk_flag <= 1'b0;
        end else if (key_valid) begin
            brk_flag <= (keycode == KEY_BREAK);
        end
    end

    // Strobes are combinational so the consumer can act on the same edge.
    assign code = keycode;
    assign make = key_valid && (keycode != KEY_BREAK) && !brk_flag;
    assign brk  = key_valid && (keycode != KEY_BREAK) && brk_flag;

endmodule

// File: rtl/game_ctrl.sv
// Two-player paddle game controller: key hold registers, serve/play/score FSM.
// Optional PAUSE state enabled by defining GAME_CTRL_PAUSE_EN.
module game_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         keycode,
    input  logic               key_valid,
    input  logic               frame_tick,
    input  logic               ball_miss,
    input  logic               miss_side,
    output logic [7:0]         key0,
    output logic [7:0]         key1,
    output logic               space,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [2:0]         state,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);

    state_t     cur;
    logic [7:0] hold0;
    logic [7:0] hold1;
    logic [7:0] frame_cnt;
    logic       pt_side;
    logic [7:0] code;
    logic       make;
    logic       brk;
    logic       start_mk;
    logic       pause_mk;

    ps2_key_decoder u_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .keycode   (keycode),
        .key_valid (key_valid),
        .code      (code),
        .make      (make),
        .brk       (brk)
    );

    assign start_mk = make && (code == KEY_START);
    assign pause_mk = make && (code == KEY_PAUSE);

    // Hold registers track keys regardless of game state; last-pressed wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold0 <= 8'h00;
            hold1 <= 8'h00;
        end else begin
            if (make && (code == KEY_P0_UP || code == KEY_P0_DN)) hold0 <= code;
            else if (brk && code == hold0)                        hold0 <= 8'h00;
            if (make && (code == KEY_P1_UP || code == KEY_P1_DN)) hold1 <= code;
            else if (brk && code == hold1)                        hold1 <= 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= ST_IDLE;
            space     <= 1'b0;
            score0    <= '0;
            score1    <= '0;
            winner    <= 1'b0;
            frame_cnt <= 8'd0;
            pt_side   <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE, ST_OVER: begin
                    if (start_mk) begin
                        cur       <= ST_SERVE;
                        score0    <= '0;
                        score1    <= '0;
                        frame_cnt <= 8'd0;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            cur       <= ST_PLAY;
                            space     <= 1'b1;
                            frame_cnt <= 8'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (ball_miss) begin
                        cur     <= ST_POINT;
                        space   <= 1'b0;
                        pt_side <= ~miss_side;
                        if (miss_side) score0 <= score_inc(score0);
                        else           score1 <= score_inc(score1);
                    end
`ifdef GAME_CTRL_PAUSE_EN
                    else if (pause_mk) begin
                        cur   <= ST_PAUSE;
                        space <= 1'b0;
                    end
`endif
                end
                ST_POINT: begin
                    if ((pt_side ? score1 : score0) == WIN_VAL) begin
                        cur    <= ST_OVER;
                        winner <= pt_side;
                    end else begin
                        cur       <= ST_SERVE;
                        frame_cnt <= 8'd0;
                    end
                end
`ifdef GAME_CTRL_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_mk) begin
                        cur   <= ST_PLAY;
                        space <= 1'b1;
                    end
                end
`endif
                default: begin
                    cur   <= ST_IDLE;
                    space <= 1'b0;
                end
            endcase
        end
    end

    assign key0  = (cur == ST_SERVE || cur == ST_PLAY) ? hold0 : 8'h00;
    assign key1  = (cur == ST_SERVE || cur == ST_PLAY) ? hold1 : 8'h00;
    assign state = cur;

endmodule
